// File: rtl/dla_pkg.sv
// Shared definitions for the weight skew feeder.
// Holds the default geometry (element width, column count, buffer read latency),
// the ping-pong upper-half base address, the FSM state type and a helper that
// turns a requested row count into the last 7-bit row index.
package dla_pkg;

  localparam int unsigned DATA_WID = 16;
  localparam int unsigned COLS     = 8;
  localparam int unsigned RD_LAT   = 2;

  localparam logic [7:0] MID_ADDR = 8'h80;
  localparam logic [7:0] MAX_LEN  = 8'd128;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StDrain,
    StDone
  } feed_state_e;

  // Last row index for a non-zero length; lengths above one half are clamped.
  function automatic logic [6:0] last_row(input logic [7:0] len);
    if (len > MAX_LEN) begin
      return 7'd127;
    end
    return 7'(len - 8'd1);
  endfunction

endpackage

// File: rtl/wgt_skew_line.sv
// Fixed-depth delay line for one weight lane, carrying a valid bit alongside data.
// Data is zeroed on entry when not valid, so the output word is 0 whenever out_vld is 0.
// Ports:
//   clock, rst_n       - clock, asynchronous active-low reset
//   en                 - advance enable; 0 freezes every stage
//   in_vld, in_data    - lane input
//   out_vld, out_data  - lane output, DEPTH cycles later
module wgt_skew_line #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WID   = 16
) (
  input  logic           clock,
  input  logic           rst_n,
  input  logic           en,
  input  logic           in_vld,
  input  logic [WID-1:0] in_data,
  output logic           out_vld,
  output logic [WID-1:0] out_data
);

  logic [DEPTH-1:0] vld_q;
  logic [WID-1:0]   data_q [DEPTH];

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_q[i] <= '0;
      end
    end else if (en) begin
      vld_q[0]  <= in_vld;
      data_q[0] <= in_vld ? in_data : '0;
      for (int i = 1; i < int'(DEPTH); i++) begin
        vld_q[i]  <= vld_q[i-1];
        data_q[i] <= data_q[i-1];
      end
    end
  end

  assign out_vld  = vld_q[DEPTH-1];
  assign out_data = data_q[DEPTH-1];

endmodule

// File: rtl/wgt_skew_feeder.sv
// Streams one weight matrix out of a ping-pong weight buffer into a systolic array,
// skewing lane j by j extra cycles so each column reaches its PE column in step.
// Optional feature macro: WGT_FEED_STALL_EN adds the stall input and a skid buffer.
// Ports:
//   clock, rst_n                  - clock, asynchronous active-low reset
//   feed_start, bank_sel, feed_len - start request, buffer half, row count K
//   busy, done                    - feed in progress, one-cycle completion pulse
//   buf_rd_en, buf_rd_addr        - weight buffer read port (request side)
//   buf_rd_data                   - row data, valid RD_LAT cycles after a read
//   pe_wgt, pe_vld                - skewed lane data and per-lane valid
//   stall                         - array back-pressure (WGT_FEED_STALL_EN only)
module wgt_skew_feeder #(
  parameter int unsigned DATA_WID = dla_pkg::DATA_WID,
  parameter int unsigned COLS     = dla_pkg::COLS,
  parameter int unsigned RD_LAT   = dla_pkg::RD_LAT
) (
  input  logic                     clock,
  input  logic                     rst_n,
  input  logic                     feed_start,
  input  logic                     bank_sel,
  input  logic [7:0]               feed_len,
  output logic                     busy,
  output logic                     done,
  output logic                     buf_rd_en,
  output logic [7:0]               buf_rd_addr,
  input  logic [COLS*DATA_WID-1:0] buf_rd_data,
  output logic [COLS*DATA_WID-1:0] pe_wgt,
  output logic [COLS-1:0]          pe_vld
`ifdef WGT_FEED_STALL_EN
  ,
  input  logic                     stall
`endif
);

  import dla_pkg::*;

  localparam int unsigned ROW_W    = COLS * DATA_WID;
  localparam int unsigned DRAIN_LEN = RD_LAT + COLS;

  feed_state_e state_q;
  logic        busy_q, done_q, rd_en_q, bank_q;
  logic [6:0]  row_q, last_row_q;
  logic [7:0]  drain_q;
  logic        stall_w;

`ifdef WGT_FEED_STALL_EN
  assign stall_w = stall;
`else
  assign stall_w = 1'b0;
`endif

  // READ and DRAIN freeze under stall; IDLE and DONE keep moving so done stays one cycle.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      bank_q     <= 1'b0;
      row_q      <= '0;
      last_row_q <= '0;
      drain_q    <= '0;
    end else if (!stall_w || state_q == StIdle || state_q == StDone) begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (feed_start) begin
            bank_q <= bank_sel;
            row_q  <= '0;
            if (feed_len == 8'd0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q    <= StRead;
              busy_q     <= 1'b1;
              rd_en_q    <= 1'b1;
              last_row_q <= last_row(feed_len);
            end
          end
        end
        StRead: begin
          if (row_q == last_row_q) begin
            state_q <= StDrain;
            rd_en_q <= 1'b0;
            drain_q <= '0;
          end else begin
            row_q <= row_q + 7'd1;
          end
        end
        StDrain: begin
          if (drain_q == 8'(DRAIN_LEN - 1)) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q + 8'd1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign buf_rd_en   = rd_en_q & ~stall_w;
  // Row index is 7 bits, so the address can never leave the selected half.
  assign buf_rd_addr = (bank_q ? MID_ADDR : 8'h00) | {1'b0, row_q};

  // Tracks issued reads through the buffer latency; keeps running under stall
  // because the buffer itself does not stop.
  logic [RD_LAT-1:0] rd_pipe_q;
  logic              arr_vld;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rd_pipe_q <= '0;
    end else begin
      rd_pipe_q[0] <= buf_rd_en;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        rd_pipe_q[i] <= rd_pipe_q[i-1];
      end
    end
  end

  assign arr_vld = rd_pipe_q[RD_LAT-1];

  logic [ROW_W-1:0] lane_in_data;
  logic             lane_in_vld;
  logic             lane_en;

`ifdef WGT_FEED_STALL_EN
  localparam int unsigned PTR_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int unsigned CNT_W = $clog2(RD_LAT + 1);

  logic [ROW_W-1:0] skid_q [RD_LAT];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] skid_cnt_q;
  logic             skid_any, skid_push, skid_pop;

  // Once anything is queued, arrivals must queue behind it to keep row order.
  assign skid_any  = (skid_cnt_q != '0);
  assign skid_push = arr_vld & (stall | skid_any);
  assign skid_pop  = ~stall & skid_any;

  assign lane_en      = ~stall;
  assign lane_in_vld  = skid_any | arr_vld;
  assign lane_in_data = skid_any ? skid_q[rd_ptr_q] : buf_rd_data;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(RD_LAT); i++) begin
        skid_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      skid_cnt_q <= '0;
    end else begin
      if (skid_push) begin
        skid_q[wr_ptr_q] <= buf_rd_data;
        wr_ptr_q <= (wr_ptr_q == PTR_W'(RD_LAT - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (skid_pop) begin
        rd_ptr_q <= (rd_ptr_q == PTR_W'(RD_LAT - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      skid_cnt_q <= skid_cnt_q + CNT_W'(skid_push) - CNT_W'(skid_pop);
    end
  end
`else
  assign lane_en      = 1'b1;
  assign lane_in_vld  = arr_vld;
  assign lane_in_data = buf_rd_data;
`endif

  // Lane j: one capture stage plus j skew stages.
  for (genvar j = 0; j < int'(COLS); j++) begin : g_lane
    wgt_skew_line #(
      .DEPTH (j + 1),
      .WID   (DATA_WID)
    ) u_line (
      .clock    (clock),
      .rst_n    (rst_n),
      .en       (lane_en),
      .in_vld   (lane_in_vld),
      .in_data  (lane_in_data[j*DATA_WID +: DATA_WID]),
      .out_vld  (pe_vld[j]),
      .out_data (pe_wgt[j*DATA_WID +: DATA_WID])
    );
  end

endmodule

// File: tb/tb_wgt_skew_feeder.sv
// Directed bench for wgt_skew_feeder at default geometry (16-bit, 8 lanes, latency 2).
// Buffer row at address a holds {a, j} in lane j.
module tb_wgt_skew_feeder;

  localparam int DW        = 16;
  localparam int NC        = 8;
  localparam int BW        = NC * DW;
  localparam int DRAIN_LEN = 10;  // read latency 2 + 8 lanes
  localparam int FIRST_OUT = 3;   // lane 0 emits a row 3 cycles after its read

  logic          clock = 1'b0;
  logic          rst_n = 1'b0;
  logic          feed_start = 1'b0;
  logic          bank_sel = 1'b0;
  logic [7:0]    feed_len = 8'd0;
  logic          busy, done, buf_rd_en;
  logic [7:0]    buf_rd_addr;
  logic [BW-1:0] buf_rd_data;
  logic [BW-1:0] pe_wgt;
  logic [NC-1:0] pe_vld;
`ifdef WGT_FEED_STALL_EN
  logic          stall = 1'b0;
`endif

  int tests = 0;
  int fails = 0;

  wgt_skew_feeder dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .feed_start  (feed_start),
    .bank_sel    (bank_sel),
    .feed_len    (feed_len),
    .busy        (busy),
    .done        (done),
    .buf_rd_en   (buf_rd_en),
    .buf_rd_addr (buf_rd_addr),
    .buf_rd_data (buf_rd_data),
    .pe_wgt      (pe_wgt),
`ifdef WGT_FEED_STALL_EN
    .stall       (stall),
`endif
    .pe_vld      (pe_vld)
  );

  always #5 clock = ~clock;

  // Weight buffer model with two-cycle read latency; junk when no read returns.
  logic       s1_v = 1'b0, s2_v = 1'b0;
  logic [7:0] s1_a = 8'd0, s2_a = 8'd0;

  always @(posedge clock) begin
    s1_v <= buf_rd_en;
    s1_a <= buf_rd_addr;
    s2_v <= s1_v;
    s2_a <= s1_a;
  end

  function automatic logic [DW-1:0] row_word(input logic [7:0] a, input int j);
    return {a, 8'(j)};
  endfunction

  always_comb begin
    buf_rd_data = '0;
    for (int j = 0; j < NC; j++) begin
      buf_rd_data[j*DW +: DW] = s2_v ? row_word(s2_a, j) : (16'hBAD0 | 16'(j));
    end
  end

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, BW'(busy), '0);
    chk({tag, "_done"}, BW'(done), '0);
    chk({tag, "_rd_en"}, BW'(buf_rd_en), '0);
    chk({tag, "_rd_addr"}, BW'(buf_rd_addr), '0);
    chk({tag, "_pe_vld"}, BW'(pe_vld), '0);
    chk({tag, "_pe_wgt"}, pe_wgt, '0);
  endtask

  // Leaves the caller 1 time unit into the first cycle after the start was sampled.
  task automatic start_feed(input logic b, input logic [7:0] len);
    @(posedge clock); #1;
    bank_sel   = b;
    feed_len   = len;
    feed_start = 1'b1;
    @(posedge clock); #1;
    feed_start = 1'b0;
  endtask

  // Runs one feed and checks every output every cycle against a timeline model.
  // glitch_c: cycle at which a stray start is pulsed (-1 none).
  // stall_c: first of three stall cycles (-1 none).
  task automatic run_feed(input logic b, input logic [7:0] len, input int k,
                          input int glitch_c, input int stall_c);
    int            last, x, r, reads, dones;
    logic          stalled, exp_en, exp_busy, exp_done;
    logic [7:0]    base;
    logic [NC-1:0] exp_vld;
    logic [BW-1:0] exp_wgt;
    base  = b ? 8'h80 : 8'h00;
    last  = (k == 0) ? 3 : k + DRAIN_LEN + 4;
    if (stall_c >= 0) last += 3;
    reads = 0;
    dones = 0;
    start_feed(b, len);
    for (int c = 0; c <= last; c++) begin
      if (c > 0) begin
        @(posedge clock); #1;
      end
      feed_start = (c == glitch_c);
      if (c == glitch_c) begin
        bank_sel = ~b;
        feed_len = 8'd3;
      end
      stalled = (stall_c >= 0) && (c >= stall_c) && (c < stall_c + 3);
`ifdef WGT_FEED_STALL_EN
      stall = stalled;
`endif
      // Equivalent unstalled cycle: state holds during the stall window and one cycle after.
      if (stall_c < 0 || c < stall_c) x = c;
      else if (c <= stall_c + 3)      x = stall_c;
      else                            x = c - 3;
      exp_en   = !stalled && (k > 0) && (x < k);
      exp_busy = (k > 0) && (x < k + DRAIN_LEN);
      exp_done = (x == ((k == 0) ? 0 : k + DRAIN_LEN));
      exp_vld  = '0;
      exp_wgt  = '0;
      for (int j = 0; j < NC; j++) begin
        r = x - FIRST_OUT - j;
        if (k > 0 && r >= 0 && r < k) begin
          exp_vld[j] = 1'b1;
          exp_wgt[j*DW +: DW] = row_word(base | 8'(r), j);
        end
      end
      @(negedge clock);
      chk("rd_en", BW'(buf_rd_en), BW'(exp_en));
      if (exp_en) chk("rd_addr", BW'(buf_rd_addr), BW'(base | 8'(x)));
      chk("busy", BW'(busy), BW'(exp_busy));
      chk("done", BW'(done), BW'(exp_done));
      chk("pe_vld", BW'(pe_vld), BW'(exp_vld));
      chk("pe_wgt", pe_wgt, exp_wgt);
      if (buf_rd_en) reads++;
      if (done) dones++;
    end
    feed_start = 1'b0;
`ifdef WGT_FEED_STALL_EN
    stall = 1'b0;
`endif
    chk("read_count", BW'(reads), BW'(k));
    chk("done_count", BW'(dones), BW'(1));
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk_all_zero("reset");
    @(posedge clock); #1;
    rst_n = 1'b1;

    // Bank 0, K=9
    run_feed(1'b0, 8'd9, 9, -1, -1);
    // Bank 1, K=128: 80..FF, no wrap
    run_feed(1'b1, 8'd128, 128, -1, -1);
    // Zero length: no reads, done right away
    run_feed(1'b0, 8'd0, 0, -1, -1);
    // Over-length clamps to 128
    run_feed(1'b0, 8'd200, 128, -1, -1);
    // Stray start mid-READ is ignored
    run_feed(1'b1, 8'd5, 5, 2, -1);

    // Reset mid-DRAIN
    start_feed(1'b0, 8'd9);
    repeat (12) @(posedge clock);
    #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(negedge clock);
    chk_all_zero("rst_held");
    @(posedge clock); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      chk("post_rst_done", BW'(done), '0);
      chk("post_rst_vld", BW'(pe_vld), '0);
    end

    // Clean feed after reset
    run_feed(1'b1, 8'd9, 9, -1, -1);

`ifdef WGT_FEED_STALL_EN
    // Three stall cycles where row 4 would be read
    run_feed(1'b0, 8'd9, 9, -1, 4);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wgt_skew_feeder.md
WGT_SKEW_FEEDER -- requirements
Module: wgt_skew_feeder

Interface
REQ-001 SHALL have parameter DATA_WID, default 16, weight element width (INT16).
REQ-002 SHALL have parameter COLS, default 8, number of weight-matrix columns (one per img2col_weight sub-unit) and PE columns.
REQ-003 SHALL have parameter RD_LAT, default 2, weight buffer read latency in cycles.
REQ-004 SHALL have port clock, input, 1, sole clock; all state on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port feed_start, input, 1, one-cycle request to stream one weight matrix.
REQ-007 SHALL have port bank_sel, input, 1, ping-pong half: 0 selects base 8'h00, 1 selects base 8'h80.
REQ-008 SHALL have port feed_len, input, 8, row count K (kernel_size squared times kernels), legal 1..128.
REQ-009 SHALL have port busy, output, 1, high from the cycle after an accepted start until done.
REQ-010 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port buf_rd_en, output, 1, weight buffer read strobe.
REQ-012 SHALL have port buf_rd_addr, output, 8, weight buffer row address.
REQ-013 SHALL have port buf_rd_data, input, COLS*DATA_WID, row data, valid RD_LAT cycles after buf_rd_en.
REQ-014 SHALL have port pe_wgt, output, COLS*DATA_WID, skewed weights to the systolic array; lane j is bits [j*DATA_WID +: DATA_WID].
REQ-015 SHALL have port pe_vld, output, COLS, per-lane valid.
REQ-016 SHALL have port stall, input, 1, array back-pressure; present only with WGT_FEED_STALL_EN.

Function
REQ-017 SHALL implement FSM IDLE -> READ -> DRAIN -> DONE -> IDLE.
REQ-018 IDLE: feed_start SHALL latch bank_sel and feed_len and enter READ; feed_start outside IDLE SHALL be ignored.
REQ-019 feed_len 0 SHALL go IDLE -> DONE with no reads; feed_len above 128 SHALL be clamped to 128.
REQ-020 READ SHALL assert buf_rd_en for exactly K unstalled cycles at addresses base, base+1, ..., base+K-1, then enter DRAIN.
REQ-021 Address SHALL be 8-bit, base plus 7-bit row index, never crossing into the other half.
REQ-022 Row data SHALL be captured RD_LAT cycles after its read; lane j SHALL be delayed j further cycles before pe_wgt.
REQ-023 For a read issued in cycle t (no stall), lane j SHALL output that row in cycle t+RD_LAT+1+j with pe_vld[j]=1.
REQ-024 pe_wgt lanes SHALL be 0 whenever the corresponding pe_vld bit is 0.
REQ-025 DRAIN SHALL last RD_LAT+COLS cycles, until the last row has left lane COLS-1, then enter DONE.
REQ-026 DONE SHALL last one cycle with done=1, busy=0; an accepted feed_start SHALL not assert done again before the next DONE.

Reset
REQ-027 On rst_n low, at any time including mid-feed, SHALL return to IDLE and clear busy, done, buf_rd_en, buf_rd_addr, pe_wgt, pe_vld and all delay-line contents to 0; in-flight reads SHALL be discarded.

Configuration
REQ-028 With WGT_FEED_STALL_EN defined, stall=1 SHALL hold buf_rd_en low and freeze address, counters, FSM and all lane delay lines; returning data SHALL be held in an RD_LAT-deep skid buffer so no row is lost or duplicated.
REQ-029 Without WGT_FEED_STALL_EN, the stall port and skid buffer SHALL be absent and behaviour SHALL equal stall tied to 0.

Structure
REQ-030 Package dla_pkg SHALL hold DATA_WID, COLS, RD_LAT, MID_ADDR (8'h80) and the FSM state enum.
REQ-031 SHALL instantiate one sub-module per lane, wgt_skew_line, a parameterised DEPTH-stage delay line with valid bit and freeze enable.

Verification
REQ-032 Bank 0, K=9, rows r at address r: reads 8'h00..8'h08 in 9 consecutive cycles; lane j emits rows 0..8 starting at t0+3+j; done once.
REQ-033 Bank 1, K=128: addresses 8'h80..8'hFF, no wrap to 8'h00; final row on lane 7 precedes done by exactly one cycle.
REQ-034 feed_len=0 -> zero reads, done one cycle after the start pulse; feed_len=200 -> exactly 128 reads.
REQ-035 feed_start pulsed mid-READ -> ignored; rst_n low mid-DRAIN -> all outputs 0 next cycle, no done; new feed after reset runs cleanly.
REQ-036 With WGT_FEED_STALL_EN, K=9, stall high for 3 cycles at row 4 -> every lane emits rows 0..8 in order, each exactly once, shifted by 3 cycles.
